// File: rtl/circuito_jogo_sequencia.sv
// Sequence game: FSM + datapath comparing edge-detected one-hot plays against a fixed ROM.
// Optional timeout in ESPERA is enabled by defining TIMEOUT_EN.
module circuito_jogo_sequencia #(
  parameter int unsigned NUM_CHAVES     = 4,
  parameter int unsigned PROF           = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned ULTIMO         = 16,
  parameter int unsigned TIMEOUT_CICLOS = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [NUM_CHAVES-1:0] chaves,
  output logic                  pronto,
  output logic                  acertou,
  output logic                  errou,
  output logic                  timeout,
  output logic                  db_igual,
  output logic                  db_jogada,
  output logic [ADDR_W-1:0]     db_contagem,
  output logic [NUM_CHAVES-1:0] db_memoria,
  output logic [NUM_CHAVES-1:0] db_chaves,
  output logic [3:0]            db_estado
);

  typedef enum logic [3:0] {
    Inicial    = 4'h0,
    Preparacao = 4'h1,
    Espera     = 4'h2,
    Registra   = 4'h4,
    Compara    = 4'h5,
    Proximo    = 4'h6,
    FimAcerto  = 4'hA,
    FimTimeout = 4'hD,
    FimErro    = 4'hE
  } estado_e;

  localparam logic [ADDR_W-1:0] UltimoIdx = ADDR_W'(ULTIMO - 1);

  estado_e               estado_q, estado_d;
  logic [ADDR_W-1:0]     contagem_q, contagem_d;
  logic [NUM_CHAVES-1:0] chaves_reg_q, chaves_reg_d;
  logic [NUM_CHAVES-1:0] chaves_ant_q;
  logic [NUM_CHAVES-1:0] memoria;
  logic                  jogada;
  logic                  igual;
  logic                  expira;

  // ROM word i is one-hot at bit (i mod NUM_CHAVES); addresses past PROF read as zero.
  always_comb begin
    memoria = '0;
    if (int'(contagem_q) < int'(PROF)) begin
      memoria = NUM_CHAVES'(1) << (int'(contagem_q) % int'(NUM_CHAVES));
    end
  end

  assign jogada = (|chaves) & ~(|chaves_ant_q);
  assign igual  = (chaves_reg_q == memoria);

`ifdef TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [TimerW-1:0] timer_q, timer_d;

  assign expira = (estado_q == Espera) && (timer_q == TimerW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    timer_d = '0;
    if ((estado_q == Espera) && (estado_d == Espera)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign expira             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CICLOS == 0);
`endif

  always_comb begin
    estado_d     = estado_q;
    contagem_d   = contagem_q;
    chaves_reg_d = chaves_reg_q;
    unique case (estado_q)
      Inicial: begin
        if (iniciar) estado_d = Preparacao;
      end
      Preparacao: begin
        contagem_d   = '0;
        chaves_reg_d = '0;
        estado_d     = Espera;
      end
      Espera: begin
        // A play arriving on the expiry cycle still counts.
        if (jogada) begin
          estado_d = Registra;
        end else if (expira) begin
          estado_d = FimTimeout;
        end
      end
      Registra: begin
        chaves_reg_d = chaves;
        estado_d     = Compara;
      end
      Compara: begin
        if (!igual) begin
          estado_d = FimErro;
        end else if (contagem_q == UltimoIdx) begin
          estado_d = FimAcerto;
        end else begin
          estado_d = Proximo;
        end
      end
      Proximo: begin
        contagem_d = contagem_q + 1'b1;
        estado_d   = Espera;
      end
      FimAcerto, FimErro, FimTimeout: begin
        if (iniciar) estado_d = Preparacao;
      end
      default: estado_d = Inicial;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= Inicial;
      contagem_q   <= '0;
      chaves_reg_q <= '0;
      chaves_ant_q <= '0;
    end else begin
      estado_q     <= estado_d;
      contagem_q   <= contagem_d;
      chaves_reg_q <= chaves_reg_d;
      chaves_ant_q <= chaves;
    end
  end

  assign pronto      = (estado_q == FimAcerto) || (estado_q == FimErro) || (estado_q == FimTimeout);
  assign acertou     = (estado_q == FimAcerto);
  assign errou       = (estado_q == FimErro) || (estado_q == FimTimeout);
  assign timeout     = (estado_q == FimTimeout);
  assign db_igual    = igual;
  assign db_jogada   = jogada;
  assign db_contagem = contagem_q;
  assign db_memoria  = memoria;
  assign db_chaves   = chaves_reg_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_circuito_jogo_sequencia.sv
// Directed bench for circuito_jogo_sequencia with ULTIMO=4 and TIMEOUT_CICLOS=50.
module tb_circuito_jogo_sequencia;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       pronto, acertou, errou, timeout, db_igual, db_jogada;
  logic [3:0] db_contagem, db_memoria, db_chaves, db_estado;

  int n_cmp = 0;
  int n_err = 0;

  circuito_jogo_sequencia #(
    .NUM_CHAVES    (4),
    .PROF          (16),
    .ADDR_W        (4),
    .ULTIMO        (4),
    .TIMEOUT_CICLOS(50)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .chaves     (chaves),
    .pronto     (pronto),
    .acertou    (acertou),
    .errou      (errou),
    .timeout    (timeout),
    .db_igual   (db_igual),
    .db_jogada  (db_jogada),
    .db_contagem(db_contagem),
    .db_memoria (db_memoria),
    .db_chaves  (db_chaves),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic flags(input string tag, input logic [3:0] exp_pate);
    check({tag, ".pronto"},  32'(pronto),  32'(exp_pate[3]));
    check({tag, ".acertou"}, 32'(acertou), 32'(exp_pate[2]));
    check({tag, ".errou"},   32'(errou),   32'(exp_pate[1]));
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_pate[0]));
  endtask

  // Play held 3 cycles then released for 2; ends back in ESPERA for non-final plays.
  task automatic play(input logic [3:0] v);
    chaves = v;
    #1;
    check("play.jogada_rise", 32'(db_jogada), 32'd1);
    step(1);
    check("play.jogada_once", 32'(db_jogada), 32'd0);
    step(2);
    check("play.db_chaves", 32'(db_chaves), 32'(v));
    chaves = 4'b0000;
    step(2);
  endtask

  task automatic start_round();
    iniciar = 1'b1;
    step(1);
    check("start.preparacao", 32'(db_estado), 32'h1);
    iniciar = 1'b0;
    step(1);
    check("start.espera", 32'(db_estado), 32'h2);
    check("start.contagem", 32'(db_contagem), 32'd0);
  endtask

  initial begin
    int pulses;
    reset   = 1'b0;
    iniciar = 1'b0;
    chaves  = 4'b0000;
    step(2);
    flags("reset", 4'b0000);
    check("reset.estado",   32'(db_estado),   32'h0);
    check("reset.contagem", 32'(db_contagem), 32'd0);
    check("reset.memoria",  32'(db_memoria),  32'h1);
    check("reset.db_chaves", 32'(db_chaves),  32'h0);
    check("reset.igual",    32'(db_igual),    32'd0);
    reset = 1'b1;
    step(2);
    check("idle.estado", 32'(db_estado), 32'h0);

    // Full correct round.
    start_round();
    play(4'b0001);
    check("ok.contagem1", 32'(db_contagem), 32'd1);
    check("ok.memoria1",  32'(db_memoria),  32'h2);
    play(4'b0010);
    play(4'b0100);
    check("ok.contagem3", 32'(db_contagem), 32'd3);
    check("ok.memoria3",  32'(db_memoria),  32'h8);
    play(4'b1000);
    flags("ok", 4'b1100);
    check("ok.estado",   32'(db_estado),   32'hA);
    check("ok.contagem", 32'(db_contagem), 32'd3);
    step(3);
    check("ok.hold", 32'(db_estado), 32'hA);

    // Restart from FIM_ACERTO.
    iniciar = 1'b1;
    step(1);
    check("restart.preparacao", 32'(db_estado), 32'h1);
    flags("restart", 4'b0000);
    iniciar = 1'b0;
    step(1);
    check("restart.espera",   32'(db_estado),   32'h2);
    check("restart.contagem", 32'(db_contagem), 32'd0);
    check("restart.db_chaves", 32'(db_chaves),  32'h0);

    // Mismatch at index 2.
    play(4'b0001);
    play(4'b0010);
    chaves = 4'b0001;
    step(2);
    check("err.compara", 32'(db_estado), 32'h5);
    check("err.igual",   32'(db_igual),  32'd0);
    check("err.none_yet", 32'(pronto),   32'd0);
    step(1);
    flags("err", 4'b1010);
    check("err.estado",   32'(db_estado),   32'hE);
    check("err.contagem", 32'(db_contagem), 32'd2);
    chaves = 4'b0000;
    step(2);
    check("err.hold", 32'(db_estado), 32'hE);

    // Held input counts as a single play.
    start_round();
    chaves = 4'b0001;
    #1;
    pulses = 32'(db_jogada);
    for (int i = 0; i < 10; i++) begin
      step(1);
      pulses += 32'(db_jogada);
    end
    check("hold.pulses",   32'(pulses),      32'd1);
    check("hold.contagem", 32'(db_contagem), 32'd1);
    check("hold.estado",   32'(db_estado),   32'h2);
    chaves = 4'b0000;
    step(1);

    // Asynchronous reset mid-round at contagem 2.
    play(4'b0010);
    check("areset.pre_contagem", 32'(db_contagem), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    flags("areset", 4'b0000);
    check("areset.estado",   32'(db_estado),   32'h0);
    check("areset.contagem", 32'(db_contagem), 32'd0);
    #3;
    reset = 1'b1;
    step(2);
    check("areset.idle", 32'(db_estado), 32'h0);

    // No play for 50 cycles.
    start_round();
    step(49);
    check("to.still_espera", 32'(db_estado), 32'h2);
    step(1);
`ifdef TIMEOUT_EN
    flags("to", 4'b1011);
    check("to.estado", 32'(db_estado), 32'hD);
`else
    flags("to", 4'b0000);
    check("to.estado", 32'(db_estado), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
